// File: rtl/fir_sample_sequencer.sv
// rtl/fir_sample_sequencer.sv - per-sample FIR shift/MAC sequencer with saturated output
// Optional define FIR_ROUND_EN: round-half-up each tap product instead of truncating.
module fir_sample_sequencer #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     data_ready,
  input  logic [DATA_W-1:0]        sample_data,
  input  logic [TAPS*DATA_W-1:0]   coeffs,
  input  logic                     load_coeff,
  output logic                     modwait,
  output logic [DATA_W-1:0]        fir_out,
  output logic                     cnt_up,
  output logic                     clear,
  output logic                     err
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + $clog2(TAPS) + 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [PROD_W-1:0] HALF_LSB = PROD_W'(1) << (DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, MAC, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]         dly_q [TAPS];
  logic [DATA_W-1:0]         dly_d [TAPS];
  logic [DATA_W-1:0]         smp_q, smp_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      ovr_q, ovr_d;
  logic [DATA_W-1:0]         fir_out_q, fir_out_d;
  logic                      err_q, err_d;
  logic                      clear_q, clear_d;

  logic                      last_tap;
  logic [DATA_W-1:0]         coef;
  logic [PROD_W-1:0]         prod, prod_r;
  logic [DATA_W-1:0]         term;
  logic signed [ACC_W-1:0]   term_ext, acc_sum;
  logic                      sat_lo, sat_hi;
  logic [DATA_W-1:0]         sat_val;

  assign last_tap = (idx_q == IDX_W'(TAPS - 1));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      for (int i = 0; i < TAPS; i++) dly_q[i] <= '0;
      smp_q     <= '0;
      acc_q     <= '0;
      ovr_q     <= 1'b0;
      fir_out_q <= '0;
      err_q     <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      smp_q     <= smp_d;
      acc_q     <= acc_d;
      ovr_q     <= ovr_d;
      fir_out_q <= fir_out_d;
      err_q     <= err_d;
      clear_q   <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_coeff)      state_d = IDLE;
        else if (data_ready) state_d = SHIFT;
        else                 state_d = IDLE;
      end
      SHIFT: begin
        state_d = MAC;
        idx_d   = '0;
      end
      MAC: begin
        if (last_tap) state_d = DONE;
        else          idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Product is at most (2^W-1)^2 + 2^(W-1), so rounding cannot carry out of PROD_W.
  always_comb begin
    coef = coeffs[idx_q*DATA_W +: DATA_W];
    prod = PROD_W'(dly_q[idx_q]) * PROD_W'(coef);
`ifdef FIR_ROUND_EN
    prod_r = prod + HALF_LSB;
`else
    prod_r = prod;
`endif
    term     = DATA_W'(prod_r >> DATA_W);
    term_ext = signed'({{(ACC_W-DATA_W){1'b0}}, term});
    acc_sum  = idx_q[0] ? (acc_q - term_ext) : (acc_q + term_ext);
    sat_lo   = acc_sum[ACC_W-1];
    sat_hi   = !sat_lo && (|acc_sum[ACC_W-2:DATA_W]);
    if (sat_lo)      sat_val = '0;
    else if (sat_hi) sat_val = '1;
    else             sat_val = acc_sum[DATA_W-1:0];
  end

  always_comb begin
    dly_d     = dly_q;
    smp_d     = smp_q;
    acc_d     = acc_q;
    ovr_d     = ovr_q;
    fir_out_d = fir_out_q;
    err_d     = err_q;
    clear_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (load_coeff) begin
          for (int i = 0; i < TAPS; i++) dly_d[i] = '0;
          clear_d = 1'b1;
        end else if (data_ready) begin
          smp_d = sample_data;
          acc_d = '0;
          ovr_d = 1'b0;
        end
      end
      SHIFT: begin
        dly_d[0] = smp_q;
        for (int i = 1; i < TAPS; i++) dly_d[i] = dly_q[i-1];
        ovr_d = ovr_q | data_ready;
      end
      MAC: begin
        ovr_d = ovr_q | data_ready;
        acc_d = acc_sum;
        if (last_tap) begin
          fir_out_d = sat_val;
          err_d     = sat_lo | sat_hi | ovr_d;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    modwait = (state_q == SHIFT) || (state_q == MAC);
    cnt_up  = (state_q == DONE);
    fir_out = fir_out_q;
    clear   = clear_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb/tb_fir_sample_sequencer.sv - scoreboard bench for fir_sample_sequencer
module tb_fir_sample_sequencer;
  localparam int DW = 16;
  localparam int TP = 4;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            data_ready = 1'b0;
  logic [DW-1:0]   sample_data = '0;
  logic [TP*DW-1:0] coeffs = '0;
  logic            load_coeff = 1'b0;
  logic            modwait;
  logic [DW-1:0]   fir_out;
  logic            cnt_up;
  logic            clear;
  logic            err;

  fir_sample_sequencer #(.DATA_W(DW), .TAPS(TP)) dut (
    .clk(clk), .n_rst(n_rst), .data_ready(data_ready), .sample_data(sample_data),
    .coeffs(coeffs), .load_coeff(load_coeff), .modwait(modwait), .fir_out(fir_out),
    .cnt_up(cnt_up), .clear(clear), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] out;
    logic          e;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] md [TP];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;

  task automatic chk(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (n_rst && cnt_up) begin
      exp_t e;
      pulses++;
      if (sb.size() == 0) begin
        chk("spurious_cnt_up", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("fir_out", fir_out, e.out);
        chk("err", err, e.e);
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input logic [DW-1:0] s, input bit ovr);
    exp_t   e;
    longint sum = 0;
    longint p;
    for (int i = TP - 1; i > 0; i--) md[i] = md[i-1];
    md[0] = s;
    for (int i = 0; i < TP; i++) begin
      p = longint'(md[i]) * longint'(coeffs[i*DW +: DW]);
`ifdef FIR_ROUND_EN
      p = p + 32768;
`endif
      p = (p >> 16) & 64'hFFFF;
      sum = (i % 2 == 1) ? sum - p : sum + p;
    end
    if (sum < 0)          begin e.out = '0; e.e = 1'b1; end
    else if (sum > 65535) begin e.out = '1; e.e = 1'b1; end
    else                  begin e.out = DW'(sum); e.e = 1'b0; end
    e.e   = e.e | ovr;
    e.due = cyc + TP + 1;
    sb.push_back(e);
  endfunction

  task automatic wait_free();
    int n = 0;
    while (modwait && n < 50) begin
      tick();
      n++;
    end
    chk("wait_free", modwait, 0);
  endtask

  // mode 0: plain sample, 1: extra strobe while busy, 2: reset mid-MAC
  task automatic send(input logic [DW-1:0] s, input int mode);
    wait_free();
    data_ready  = 1'b1;
    sample_data = s;
    tick();
    data_ready = 1'b0;
    model_push(s, mode == 1);
    if (mode == 1) begin
      tick();
      chk("ovr_busy", modwait, 1);
      data_ready  = 1'b1;
      sample_data = ~s;
      tick();
      data_ready = 1'b0;
    end else if (mode == 2) begin
      tick();
      tick();
      n_rst = 1'b0;
      tick();
      tick();
      chk("rst_mid_modwait", modwait, 0);
      chk("rst_mid_outs", {fir_out, cnt_up, clear, err}, 0);
      n_rst = 1'b1;
      sb.delete(sb.size() - 1);
      for (int i = 0; i < TP; i++) md[i] = '0;
    end
  endtask

  task automatic reload(input logic [TP*DW-1:0] cv, input bit with_dr);
    wait_free();
    coeffs      = cv;
    load_coeff  = 1'b1;
    data_ready  = with_dr;
    sample_data = 16'h1234;
    tick();
    load_coeff = 1'b0;
    data_ready = 1'b0;
    for (int i = 0; i < TP; i++) md[i] = '0;
    chk("clear_hi", clear, 1);
    chk("no_accept", modwait, 0);
    tick();
    chk("clear_lo", clear, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int p0;
    for (int i = 0; i < TP; i++) md[i] = '0;
    n_rst = 1'b0;
    tick();
    tick();
    chk("rst_modwait", modwait, 0);
    chk("rst_fir_out", fir_out, 0);
    chk("rst_cnt_up", cnt_up, 0);
    chk("rst_clear", clear, 0);
    chk("rst_err", err, 0);
    n_rst = 1'b1;
    tick();

    reload({48'h0, 16'h8000}, 1'b1);
    send(16'h1000, 0);

    reload({32'h0, 16'h8000, 16'h8000}, 1'b0);
    send(16'h1000, 0);
    send(16'h2000, 0);
    send(16'h4000, 0);
    send(16'h0000, 0);

    reload({16'h0, 16'hFFFF, 16'h0, 16'hFFFF}, 1'b0);
    send(16'hFFFF, 0);
    send(16'h0000, 0);
    send(16'hFFFF, 0);
    drain();

    reload({16'h0, 16'hFFFF, 16'h0, 16'hFFFF}, 1'b1);
    send(16'hFFFF, 0);
    send(16'h0100, 1);
    send(16'h5555, 2);
    send(16'h2222, 0);

    reload({48'h0, 16'h0001}, 1'b0);
    send(16'h8000, 0);
    drain();

    p0 = pulses;
    reload({$urandom(), $urandom()}, 1'b0);
    for (int k = 0; k < 1000; k++) send(DW'($urandom()), 0);
    drain();
    chk("pulse_count", pulses - p0, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sample_sequencer.md
# fir_sample_sequencer

Per-sample control and arithmetic stage of the FIR filter that sits directly upstream of the 1000-sample counter. It accepts each incoming sample on a data_ready handshake, shifts it into a TAPS-deep delay line, and runs one multiply-accumulate per cycle with alternating-sign taps. It registers the saturated result and pulses cnt_up once per completed sample, which drives the counter's count_enable. The clear output, raised on a coefficient reload, drives the counter's clear.

## Interface
- DATA_W, 16: sample, coefficient and output width (unsigned).
- TAPS, 4: delay-line depth and number of MAC cycles (2..8).

- clk  in  1  system clock, rising edge.
- n_rst  in  1  synchronous, active-low reset.
- data_ready  in  1  one-cycle strobe; sample_data valid.
- sample_data  in  DATA_W  unsigned sample.
- coeffs  in  TAPS*DATA_W  unsigned Q0.16 coefficients; tap i at bits [i*DATA_W +: DATA_W].
- load_coeff  in  1  coefficient-reload strobe.
- modwait  out  1  busy; new samples are not accepted while high.
- fir_out  out  DATA_W  last filter result.
- cnt_up  out  1  one-cycle pulse per completed sample.
- clear  out  1  one-cycle pulse after an accepted load_coeff.
- err  out  1  error status of the last result.

## Operation
- Reset (n_rst low at an edge): state IDLE, delay line all 0, accumulator 0, overrun flag 0. Outputs: modwait 0, fir_out 0, cnt_up 0, clear 0, err 0.
- States: IDLE, SHIFT, MAC, DONE. The MAC state has an index idx counting 0..TAPS-1.
- IDLE/DONE (modwait 0):
  - load_coeff=1: zero the delay line; clear=1 next cycle; go to IDLE. Wins over a simultaneous data_ready, which is dropped with no error.
  - Otherwise data_ready=1: capture sample_data, clear accumulator and overrun flag, go to SHIFT.
  - Otherwise: go to IDLE.
- SHIFT: d[i]←d[i-1], d[0]←captured sample; go to MAC with idx=0.
- MAC idx=i:
  - term = (d[i]*c[i])>>16, truncated, DATA_W bits.
  - Add term for even i, subtract it for odd i.
  - Accumulator is signed, DATA_W+log2(TAPS)+1 bits wide, and never wraps.
  - When i=TAPS-1: load fir_out with the saturated final sum and go to DONE.
- Saturation: a negative sum gives fir_out 0; a sum >2^DATA_W-1 gives fir_out all ones. Either case flags an arithmetic error.
- err is loaded on entry to DONE as (arithmetic error OR overrun flag). It holds until the next DONE or reset.
- data_ready seen in SHIFT or MAC: the sample is dropped and the overrun flag is set.
- load_coeff seen in SHIFT or MAC: ignored.
- modwait=1 in SHIFT and MAC only. cnt_up=1 in DONE only.
- Reset mid-operation: abort, no cnt_up, all state returns to reset values.

## Timing
- Accept on edge k.
- SHIFT during cycle k→k+1.
- MACs on edges k+2..k+1+TAPS.
- fir_out, err valid and cnt_up high in the cycle after edge k+1+TAPS; 5 cycles after accept for TAPS=4.
- Back-to-back: a data_ready during DONE is accepted; throughput is one sample per TAPS+2 cycles.
- clear is high exactly one cycle, starting the cycle after the load_coeff edge.
- All outputs are registered or decoded from state; no input-to-output combinational paths.

## Configuration
- FIR_ROUND_EN defined: each product adds 2^15 before the >>16 (round-half-up).
- FIR_ROUND_EN undefined: plain truncation.

## Test plan
- Reset: hold n_rst=0 over 2 edges mid-MAC → all outputs 0, no cnt_up; the next sample gives a result with an all-zero history.
- Single tap: c0=0x8000, others 0; sample 0x1000 → fir_out=0x0800, err=0; cnt_up one cycle, 5 cycles after accept.
- Sign and saturation:
  - c0=c1=0x8000; samples 0x1000 then 0x2000 → fir_out 0x0800, err 0.
  - Same coefficients; samples 0x4000 then 0x0000 → fir_out 0, err 1.
- Overflow: c0=c2=0xFFFF; samples 0xFFFF, 0, 0xFFFF → fir_out 0xFFFF, err 1.
- Overrun and priority:
  - data_ready during MAC → dropped, err 1 at DONE.
  - load_coeff with data_ready in IDLE → clear pulse, delay line zero, no cnt_up.
- Rounding: c0=0x0001, sample 0x8000 → fir_out 1 with FIR_ROUND_EN, 0 without; 1000 accepted samples → 1000 cnt_up pulses.
